// File: rtl/pipeline_pkg.sv
// Shared pipeline types: ALU op codes, ALU class codes, ID/EX bundle.
// Also holds the operand forwarding selector used by the issue stage.
package pipeline_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_NOR = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    CLS_MEM = 2'b00,
    CLS_BR  = 2'b01,
    CLS_R   = 2'b10,
    CLS_NOR = 2'b11
  } alu_class_e;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] store_data;
    logic [4:0]  rd;
    alu_op_e     op;
  } id_ex_t;

  // x0 is hardwired zero, so it is never a forwarding target
  function automatic logic [63:0] fwd_sel(
    input logic [4:0]  rs,
    input logic [63:0] rf_data,
    input logic        mem_en,
    input logic [4:0]  mem_rd,
    input logic [63:0] mem_data,
    input logic        wb_en,
    input logic [4:0]  wb_rd,
    input logic [63:0] wb_data
  );
    logic [63:0] r;
    r = rf_data;
    if (rs != 5'd0) begin
      if (mem_en && mem_rd == rs)
        r = mem_data;
      else if (wb_en && wb_rd == rs)
        r = wb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-to-issue handshake bundle.
// master = decode side, slave = issue stage.
interface alu_issue_stage_if;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_rs1_data;
  logic [63:0] id_rs2_data;
  logic [63:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_alu_src;
  logic [1:0]  id_alu_class;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;

  modport master (
    output id_valid, id_rs1_data, id_rs2_data,
    output id_imm, id_rs1, id_rs2, id_rd,
    output id_alu_src, id_alu_class,
    output id_funct3, id_funct7b5,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_rs1_data, id_rs2_data,
    input  id_imm, id_rs1, id_rs2, id_rd,
    input  id_alu_src, id_alu_class,
    input  id_funct3, id_funct7b5,
    output id_ready
  );
endinterface

// File: rtl/alu_control.sv
// Combinational ALU-op decode from class and function fields.
// Unknown R-type combos fall back to ADD and raise illegal.
import pipeline_pkg::*;

module alu_control (
  input  logic [1:0] alu_class,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output alu_op_e    alu_op,
  output logic       illegal
);

  logic r_add;
  logic r_sub;
  logic r_and;
  logic r_or;

  assign r_add = (funct3 == 3'b000) && !funct7b5;
  assign r_sub = (funct3 == 3'b000) && funct7b5;
  assign r_and = (funct3 == 3'b111);
  assign r_or  = (funct3 == 3'b110);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    unique case (alu_class)
      CLS_MEM: alu_op = ALU_ADD;
      CLS_BR:  alu_op = ALU_SUB;
      CLS_NOR: alu_op = ALU_NOR;
      CLS_R: begin
        unique case (1'b1)
          r_add:   alu_op = ALU_ADD;
          r_sub:   alu_op = ALU_SUB;
          r_and:   alu_op = ALU_AND;
          r_or:    alu_op = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: operand forwarding, op decode and the
// ID/EX pipeline register with valid/ready flow control.
import pipeline_pkg::*;

module alu_issue_stage (
  input  logic               clk,
  input  logic               reset_n,
  alu_issue_stage_if.slave   id,
  input  logic               fwd_mem_en,
  input  logic [4:0]         fwd_mem_rd,
  input  logic [63:0]        fwd_mem_data,
  input  logic               fwd_wb_en,
  input  logic [4:0]         fwd_wb_rd,
  input  logic [63:0]        fwd_wb_data,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [63:0]        a,
  output logic [63:0]        b,
  output logic [3:0]         ALUOp,
  output logic [4:0]         ex_rd,
  output logic [63:0]        store_data,
  output logic               illegal_op
);

  id_ex_t      ex_q;
  id_ex_t      ex_d;
  alu_op_e     dec_op;
  logic        dec_ill;
  logic [63:0] rs1_val;
  logic [63:0] rs2_val;
  logic        capture;

  alu_control u_ctl (
    .alu_class (id.id_alu_class),
    .funct3    (id.id_funct3),
    .funct7b5  (id.id_funct7b5),
    .alu_op    (dec_op),
    .illegal   (dec_ill)
  );

  assign rs1_val = fwd_sel(id.id_rs1, id.id_rs1_data,
                           fwd_mem_en, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_en, fwd_wb_rd, fwd_wb_data);
  assign rs2_val = fwd_sel(id.id_rs2, id.id_rs2_data,
                           fwd_mem_en, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_en, fwd_wb_rd, fwd_wb_data);

  assign id.id_ready = !ex_q.valid || ex_ready;
  assign capture     = id.id_valid && id.id_ready && !flush;

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d.valid   = 1'b0;
      ex_d.illegal = 1'b0;
    end else if (capture) begin
      ex_d.valid      = 1'b1;
      ex_d.illegal    = dec_ill;
      ex_d.a          = rs1_val;
      ex_d.b          = id.id_alu_src ? id.id_imm : rs2_val;
      ex_d.store_data = rs2_val;
      ex_d.rd         = id.id_rd;
      ex_d.op         = dec_op;
    end else if (ex_ready) begin
      ex_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  assign ex_valid   = ex_q.valid;
  assign illegal_op = ex_q.illegal;
  assign a          = ex_q.a;
  assign b          = ex_q.b;
  assign store_data = ex_q.store_data;
  assign ex_rd      = ex_q.rd;
  assign ALUOp      = ex_q.op;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios then random
// traffic checked against a cycle-level reference model.
module tb_alu_issue_stage;

  logic        clk;
  logic        reset_n;
  logic        fwd_mem_en;
  logic [4:0]  fwd_mem_rd;
  logic [63:0] fwd_mem_data;
  logic        fwd_wb_en;
  logic [4:0]  fwd_wb_rd;
  logic [63:0] fwd_wb_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  ALUOp;
  logic [4:0]  ex_rd;
  logic [63:0] store_data;
  logic        illegal_op;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id           (bus.slave),
    .fwd_mem_en   (fwd_mem_en),
    .fwd_mem_rd   (fwd_mem_rd),
    .fwd_mem_data (fwd_mem_data),
    .fwd_wb_en    (fwd_wb_en),
    .fwd_wb_rd    (fwd_wb_rd),
    .fwd_wb_data  (fwd_wb_data),
    .flush        (flush),
    .ex_ready     (ex_ready),
    .ex_valid     (ex_valid),
    .a            (a),
    .b            (b),
    .ALUOp        (ALUOp),
    .ex_rd        (ex_rd),
    .store_data   (store_data),
    .illegal_op   (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // reference model state: what the EX side should currently see
  logic        m_valid;
  logic        m_ill;
  logic [63:0] m_a;
  logic [63:0] m_b;
  logic [63:0] m_sd;
  logic [4:0]  m_rd;
  logic [3:0]  m_op;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_rs(input logic [4:0] rs,
                                         input logic [63:0] rf);
    if (rs == 0) return rf;
    if (fwd_mem_en && fwd_mem_rd == rs) return fwd_mem_data;
    if (fwd_wb_en && fwd_wb_rd == rs) return fwd_wb_data;
    return rf;
  endfunction

  function automatic logic [3:0] ref_op(input logic [1:0] cls,
                                       input logic [2:0] f3,
                                       input logic f7,
                                       output logic ill);
    ill = 1'b0;
    case (cls)
      2'd0: return 4'b0010;
      2'd1: return 4'b0110;
      2'd3: return 4'b1100;
      default: begin
        if (f3 == 3'd0) return f7 ? 4'b0110 : 4'b0010;
        if (f3 == 3'd7) return 4'b0000;
        if (f3 == 3'd6) return 4'b0001;
        ill = 1'b1;
        return 4'b0010;
      end
    endcase
  endfunction

  task automatic model_clear();
    m_valid = 0; m_ill = 0; m_a = 0; m_b = 0;
    m_sd = 0; m_rd = 0; m_op = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".ex_valid"}, 64'(ex_valid), 64'(m_valid));
    chk({tag, ".illegal"}, 64'(illegal_op), 64'(m_ill));
    chk({tag, ".a"}, a, m_a);
    chk({tag, ".b"}, b, m_b);
    chk({tag, ".store"}, store_data, m_sd);
    chk({tag, ".rd"}, 64'(ex_rd), 64'(m_rd));
    chk({tag, ".aluop"}, 64'(ALUOp), 64'(m_op));
  endtask

  // one cycle: check ready, predict, clock, compare
  task automatic step(input string tag);
    logic rdy;
    logic ill;
    logic [3:0] op;
    logic [63:0] r1;
    logic [63:0] r2;
    #1;
    rdy = !m_valid || ex_ready;
    chk({tag, ".id_ready"}, 64'(bus.id_ready), 64'(rdy));
    r1 = ref_rs(bus.id_rs1, bus.id_rs1_data);
    r2 = ref_rs(bus.id_rs2, bus.id_rs2_data);
    op = ref_op(bus.id_alu_class, bus.id_funct3, bus.id_funct7b5, ill);
    @(posedge clk);
    if (flush) begin
      m_valid = 0;
      m_ill = 0;
    end else if (bus.id_valid && rdy) begin
      m_valid = 1;
      m_ill = ill;
      m_a = r1;
      m_b = bus.id_alu_src ? bus.id_imm : r2;
      m_sd = r2;
      m_rd = bus.id_rd;
      m_op = op;
    end else if (ex_ready) begin
      m_valid = 0;
    end
    #1;
    chk_all(tag);
  endtask

  task automatic set_instr(input logic [1:0] cls, input logic [2:0] f3,
                           input logic f7, input logic [4:0] rs1,
                           input logic [63:0] d1, input logic [4:0] rs2,
                           input logic [63:0] d2, input logic [4:0] rd);
    bus.id_valid = 1;
    bus.id_alu_class = cls;
    bus.id_funct3 = f3;
    bus.id_funct7b5 = f7;
    bus.id_rs1 = rs1;
    bus.id_rs1_data = d1;
    bus.id_rs2 = rs2;
    bus.id_rs2_data = d2;
    bus.id_rd = rd;
    bus.id_alu_src = 0;
    bus.id_imm = 64'h0;
  endtask

  initial begin
    reset_n = 0;
    flush = 0;
    ex_ready = 1;
    fwd_mem_en = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
    fwd_wb_en = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
    set_instr(2'b10, 3'b000, 1'b1, 5'd1, 64'd10, 5'd2, 64'd3, 5'd7);
    bus.id_valid = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    chk("reset.id_ready", 64'(bus.id_ready), 64'd1);
    @(negedge clk);
    reset_n = 1;

    // subtract, captured on first edge after reset release
    bus.id_valid = 1;
    step("sub");
    chk("sub.a10", a, 64'd10);
    chk("sub.op", 64'(ALUOp), 64'b0110);

    // MEM wins over WB on the same source
    set_instr(2'b00, 3'b000, 1'b0, 5'd5, 64'h11, 5'd0, 64'h22, 5'd3);
    fwd_mem_en = 1; fwd_mem_rd = 5; fwd_mem_data = 64'hAA;
    fwd_wb_en = 1; fwd_wb_rd = 5; fwd_wb_data = 64'hBB;
    step("fwd_mem");
    chk("fwd_mem.a", a, 64'hAA);
    bus.id_rs1 = 0;
    fwd_mem_rd = 0; fwd_wb_rd = 0;
    step("fwd_x0");
    chk("fwd_x0.a", a, 64'h11);
    fwd_mem_en = 0; fwd_wb_en = 0;

    // immediate operand with WB forward on rs2
    set_instr(2'b01, 3'b000, 1'b0, 5'd4, 64'h40, 5'd6, 64'h60, 5'd9);
    bus.id_alu_src = 1; bus.id_imm = 64'hFFFF_FFFF_FFFF_FFF0;
    fwd_wb_en = 1; fwd_wb_rd = 6; fwd_wb_data = 64'h66;
    step("imm");
    fwd_wb_en = 0;

    // stall three cycles with a new instruction waiting
    ex_ready = 0;
    set_instr(2'b10, 3'b111, 1'b0, 5'd1, 64'h1234, 5'd2, 64'h5678, 5'd4);
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall.id_ready", 64'(bus.id_ready), 64'd0);
    ex_ready = 1;
    step("release");
    chk("release.op", 64'(ALUOp), 64'b0000);

    // flush beats capture
    set_instr(2'b11, 3'b000, 1'b0, 5'd3, 64'h99, 5'd3, 64'h99, 5'd8);
    flush = 1;
    step("flush");
    flush = 0;

    // illegal R-type, then a legal one clears the flag
    set_instr(2'b10, 3'b001, 1'b0, 5'd1, 64'h5, 5'd2, 64'h6, 5'd10);
    step("illegal");
    chk("illegal.flag", 64'(illegal_op), 64'd1);
    set_instr(2'b10, 3'b110, 1'b0, 5'd1, 64'h7, 5'd2, 64'h8, 5'd11);
    step("legal");
    chk("legal.flag", 64'(illegal_op), 64'd0);

    // asynchronous reset mid-stall between edges
    ex_ready = 0;
    step("pre_rst");
    #2;
    reset_n = 0;
    #1;
    model_clear();
    chk_all("async_rst");
    chk("async_rst.id_ready", 64'(bus.id_ready), 64'd1);
    #1;
    reset_n = 1;
    ex_ready = 1;
    set_instr(2'b00, 3'b000, 1'b0, 5'd2, 64'hC0DE, 5'd3, 64'hBEEF, 5'd12);
    step("post_rst");

    // random traffic
    for (int i = 0; i < 300; i++) begin
      bus.id_valid = ($urandom % 4) != 0;
      bus.id_rs1 = 5'($urandom % 4);
      bus.id_rs2 = 5'($urandom % 4);
      bus.id_rd = 5'($urandom);
      bus.id_rs1_data = {$urandom, $urandom};
      bus.id_rs2_data = {$urandom, $urandom};
      bus.id_imm = {$urandom, $urandom};
      bus.id_alu_src = 1'($urandom);
      bus.id_alu_class = 2'($urandom);
      bus.id_funct3 = 3'($urandom);
      bus.id_funct7b5 = 1'($urandom);
      fwd_mem_en = 1'($urandom);
      fwd_mem_rd = 5'($urandom % 4);
      fwd_mem_data = {$urandom, $urandom};
      fwd_wb_en = 1'($urandom);
      fwd_wb_rd = 5'($urandom % 4);
      fwd_wb_data = {$urandom, $urandom};
      ex_ready = ($urandom % 4) != 0;
      flush = ($urandom % 10) == 0;
      step("rand");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be: clk in 1, rising-edge clock; reset_n in 1, asynchronous active-low reset.
REQ-002 id_valid in 1: decode stage presents an instruction; id_ready out 1: stage can accept this cycle.
REQ-003 id_rs1_data, id_rs2_data in 64: register-file read data; id_imm in 64: sign-extended immediate.
REQ-004 id_rs1, id_rs2, id_rd in 5: source/destination register indices.
REQ-005 id_alu_src in 1: 1 selects id_imm as operand b; id_alu_class in 2: 00 mem-address, 01 branch-compare, 10 R-type, 11 NOR.
REQ-006 id_funct3 in 3, id_funct7b5 in 1: instruction function fields (bit 30 for funct7b5).
REQ-007 fwd_mem_en in 1, fwd_mem_rd in 5, fwd_mem_data in 64: EX/MEM writeback candidate; fwd_wb_en in 1, fwd_wb_rd in 5, fwd_wb_data in 64: MEM/WB candidate.
REQ-008 flush in 1: squash held instruction; ex_ready in 1: ALU/EX side accepts current output.
REQ-009 ex_valid out 1; a, b out 64: ALU operands; ALUOp out 4: ALU operation code; ex_rd out 5; store_data out 64: forwarded rs2 value; illegal_op out 1.

Function
REQ-010 id_ready SHALL equal (!ex_valid || ex_ready), combinational, and SHALL not depend on id_valid.
REQ-011 Capture SHALL occur on a rising edge where id_valid && id_ready && !flush; all outputs then update at that edge (latency 1 cycle).
REQ-012 When ex_valid=1 and ex_ready=0, all outputs SHALL hold unchanged.
REQ-013 When ex_ready=1 and no capture occurs, ex_valid SHALL go to 0 next edge; data outputs SHALL hold.
REQ-014 flush=1 SHALL force ex_valid=0 and illegal_op=0 next edge, overriding capture and hold; data outputs hold.
REQ-015 Forwarded rs value: if fwd_mem_en && fwd_mem_rd==rs && rs!=0 use fwd_mem_data; else if fwd_wb_en && fwd_wb_rd==rs && rs!=0 use fwd_wb_data; else id_rsX_data; evaluated in the capture cycle only.
REQ-016 a SHALL be forwarded rs1; store_data SHALL be forwarded rs2; b SHALL be id_imm when id_alu_src=1, else forwarded rs2.
REQ-017 ALUOp mapping: class 00 -> 0010; 01 -> 0110; 11 -> 1100; class 10: funct3=000,funct7b5=0 -> 0010; funct3=000,funct7b5=1 -> 0110; funct3=111 -> 0000; funct3=110 -> 0001.
REQ-018 Any other class-10 combination SHALL produce ALUOp=0010 and illegal_op=1 for that captured instruction; illegal_op SHALL otherwise be 0 on capture.
REQ-019 Register index 0 SHALL never be forwarded, even if fwd_*_rd=0 with enable set.
REQ-020 Simultaneous MEM and WB match on the same rs SHALL select MEM data.

Reset
REQ-021 reset_n=0 SHALL asynchronously clear ex_valid, illegal_op, a, b, store_data, ex_rd, ALUOp to 0; id_ready then reads 1.
REQ-022 Reset asserted mid-stall SHALL discard the held instruction; no output SHALL reflect pre-reset data after deassertion.
REQ-023 First capture SHALL be possible on the first rising edge after reset_n deasserts.

Structure
REQ-024 ALUOp encodings (AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100) and alu_class codes SHALL be constants in shared package pipeline_pkg.
REQ-025 ALU-op decode (REQ-017/018) SHALL be a combinational sub-module alu_control; forwarding muxes and pipeline register remain in alu_issue_stage.

Verification
REQ-026 Reset then class 10, funct3=000, funct7b5=1, rs1_data=10, rs2_data=3, ex_ready=1 -> next edge ex_valid=1, a=10, b=3, ALUOp=0110.
REQ-027 rs1=5, fwd_mem_en=1/rd=5/data=0xAA, fwd_wb_en=1/rd=5/data=0xBB -> a=0xAA; repeat with rs1=0 -> a=id_rs1_data.
REQ-028 ex_ready=0 for 3 cycles with id_valid=1 -> id_ready=0, outputs frozen; ex_ready=1 -> next instruction captured following edge.
REQ-029 flush=1 together with id_valid=1,id_ready=1 -> ex_valid=0 next edge, instruction not captured.
REQ-030 Class 10, funct3=001 -> ALUOp=0010, illegal_op=1; next legal capture -> illegal_op=0.
REQ-031 reset_n pulsed low asynchronously between edges while ex_valid=1 -> ex_valid=0, all data outputs 0 immediately.
